// File: rtl/random_pulse_burst_ctrl_pkg.sv
// Shared types and constants for the random pulse burst controller:
// FSM state encoding, Galois LFSR tap mask and the default LFSR seed.
package random_pulse_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GAP   = 2'd1,
        PULSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Right-shift Galois taps for x^16+x^14+x^13+x^11+1 (maximal length)
    localparam logic [15:0] LFSR_TAPS    = 16'hB400;
    localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

endpackage

// File: rtl/random_pulse_burst_ctrl_if.sv
// Request/config/status bundle between the top-level I/O mapping and the
// burst controller; master drives requests and config, slave returns pulses.
interface random_pulse_burst_ctrl_if #(
    parameter int GAP_W   = 8,
    parameter int BURST_W = 8
);
    logic               start_i;
    logic               abort_i;
    logic [BURST_W-1:0] cfg_burst_len;
    logic [GAP_W-1:0]   cfg_gap_min;
    logic [GAP_W-1:0]   cfg_gap_mask;
    logic               pulse_o;
    logic               busy_o;
    logic               done_o;

    modport master (
        output start_i, abort_i, cfg_burst_len, cfg_gap_min, cfg_gap_mask,
        input  pulse_o, busy_o, done_o
    );

    modport slave (
        input  start_i, abort_i, cfg_burst_len, cfg_gap_min, cfg_gap_mask,
        output pulse_o, busy_o, done_o
    );
endinterface

// File: rtl/random_pulse_burst_ctrl_lfsr_galois.sv
// Right-shifting Galois LFSR that advances once per cycle while adv is high.
// A zero SEED is replaced by 1 so the register can never lock up at zero.
module lfsr_galois #(
    parameter int               WIDTH = 16,
    parameter logic [WIDTH-1:0] TAPS  = 16'hB400,
    parameter logic [WIDTH-1:0] SEED  = 16'hACE1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             adv,
    output logic [WIDTH-1:0] q
);
    localparam logic [WIDTH-1:0] SEED_SAFE =
        (SEED == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : SEED;

    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] q_next;

    // Each bit takes its upper neighbour, XORed with the feedback bit where tapped
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
            if (gi == WIDTH - 1) begin : g_top
                assign q_next[gi] = TAPS[gi] & q_reg[0];
            end else begin : g_mid
                assign q_next[gi] = q_reg[gi+1] ^ (TAPS[gi] & q_reg[0]);
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_reg <= SEED_SAFE;
        end else if (adv) begin
            q_reg <= q_next;
        end
    end

    assign q = q_reg;

endmodule

// File: rtl/random_pulse_burst_ctrl.sv
// Start/abort controlled burst scheduler: emits cfg_burst_len single-cycle pulses
// separated by LFSR-randomised gaps. Define PULSE_CNT_EN to add pulse_count_o.
module random_pulse_burst_ctrl
    import random_pulse_pkg::*;
#(
    parameter int                LFSR_W  = 16,
    parameter int                GAP_W   = 8,
    parameter int                BURST_W = 8,
    parameter logic [LFSR_W-1:0] SEED    = DEFAULT_SEED
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    ena,
    random_pulse_burst_ctrl_if.slave bus
`ifdef PULSE_CNT_EN
    ,
    output logic [15:0]             pulse_count_o
`endif
);
    localparam logic [GAP_W:0]     GAP_ONE = 1;
    localparam logic [BURST_W-1:0] REM_ONE = 1;

    state_t             state_reg;
    logic [BURST_W-1:0] rem_reg;
    logic [GAP_W:0]     gap_cnt_reg;
    logic [GAP_W-1:0]   gap_min_reg;
    logic [GAP_W-1:0]   gap_mask_reg;

    logic [LFSR_W-1:0]  lfsr_q;
    logic [GAP_W-1:0]   lfsr_low;
    logic [GAP_W:0]     gap_first;
    logic [GAP_W:0]     gap_next;
    logic [BURST_W-1:0] rem_dec;
    logic               unused_lfsr_bits;

    lfsr_galois #(
        .WIDTH (LFSR_W),
        .TAPS  (LFSR_TAPS),
        .SEED  (SEED)
    ) u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .adv   (ena),
        .q     (lfsr_q)
    );

    assign lfsr_low         = lfsr_q[GAP_W-1:0];
    assign unused_lfsr_bits = ^lfsr_q[LFSR_W-1:GAP_W];

    // Gap sums are one bit wider than the operands so min+spread never wraps.
    // The first gap uses the live cfg inputs, later gaps the latched copies.
    assign gap_first = {1'b0, bus.cfg_gap_min} + {1'b0, lfsr_low & bus.cfg_gap_mask};
    assign gap_next  = {1'b0, gap_min_reg} + {1'b0, lfsr_low & gap_mask_reg};
    assign rem_dec   = rem_reg - REM_ONE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            rem_reg      <= '0;
            gap_cnt_reg  <= '0;
            gap_min_reg  <= '0;
            gap_mask_reg <= '0;
        end else if (ena) begin
            if (bus.abort_i) begin
                state_reg   <= IDLE;
                rem_reg     <= '0;
                gap_cnt_reg <= '0;
            end else begin
                case (state_reg)
                    IDLE: begin
                        if (bus.start_i) begin
                            gap_min_reg  <= bus.cfg_gap_min;
                            gap_mask_reg <= bus.cfg_gap_mask;
                            rem_reg      <= bus.cfg_burst_len;
                            if (bus.cfg_burst_len == '0) begin
                                state_reg <= DONE;
                            end else begin
                                state_reg   <= GAP;
                                gap_cnt_reg <= gap_first;
                            end
                        end
                    end
                    GAP: begin
                        if (gap_cnt_reg == '0) begin
                            state_reg <= PULSE;
                        end else begin
                            gap_cnt_reg <= gap_cnt_reg - GAP_ONE;
                        end
                    end
                    PULSE: begin
                        rem_reg <= rem_dec;
                        if (rem_dec == '0) begin
                            state_reg <= DONE;
                        end else begin
                            state_reg   <= GAP;
                            gap_cnt_reg <= gap_next;
                        end
                    end
                    DONE: begin
                        state_reg <= IDLE;
                    end
                    default: begin
                        state_reg <= IDLE;
                    end
                endcase
            end
        end
    end

    // A frozen PULSE state must not repeat the pulse while ena is low
    assign bus.pulse_o = (state_reg == PULSE) & ena;
    assign bus.busy_o  = (state_reg != IDLE);
    assign bus.done_o  = (state_reg == DONE);

`ifdef PULSE_CNT_EN
    logic [15:0] pulse_cnt_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pulse_cnt_reg <= '0;
        end else if (bus.pulse_o && (pulse_cnt_reg != 16'hFFFF)) begin
            pulse_cnt_reg <= pulse_cnt_reg + 16'd1;
        end
    end

    assign pulse_count_o = pulse_cnt_reg;
`endif

endmodule
